// File: rtl/store_wait_table.sv
// Per-inum store-wait table for issue select. Memory ops wait on their predicted producer store.
// Issued stores wake their dependents and are echoed back to the LFST as invalidates.
module store_wait_table #(
  parameter int TAG_W = 7,
  parameter int NENT  = 128
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush_in,
  input  logic             disp0_vld,
  input  logic [TAG_W-1:0] disp0_tag,
  input  logic             disp0_dvld,
  input  logic [TAG_W-1:0] disp0_dtag,
  input  logic             disp1_vld,
  input  logic [TAG_W-1:0] disp1_tag,
  input  logic             disp1_dvld,
  input  logic [TAG_W-1:0] disp1_dtag,
  input  logic             disp2_vld,
  input  logic [TAG_W-1:0] disp2_tag,
  input  logic             disp2_dvld,
  input  logic [TAG_W-1:0] disp2_dtag,
  input  logic             disp3_vld,
  input  logic [TAG_W-1:0] disp3_tag,
  input  logic             disp3_dvld,
  input  logic [TAG_W-1:0] disp3_dtag,
  input  logic             st_iss0_vld,
  input  logic [TAG_W-1:0] st_iss0_tag,
  input  logic             st_iss1_vld,
  input  logic [TAG_W-1:0] st_iss1_tag,
  input  logic [TAG_W-1:0] q0_tag,
  output logic             q0_ready,
  input  logic [TAG_W-1:0] q1_tag,
  output logic             q1_ready,
  output logic [TAG_W:0]   inval0_out,
  output logic [TAG_W:0]   inval1_out,
  output logic [7:0]       wait_cnt_out
);

  logic [NENT-1:0]  wait_q, wait_d;
  logic [TAG_W-1:0] dep_tag_q [NENT];
  logic [TAG_W-1:0] dep_tag_d [NENT];
  logic [TAG_W:0]   inval0_q, inval0_d, inval1_q, inval1_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;

  logic [3:0]       slot_vld, slot_dvld;
  logic [TAG_W-1:0] slot_tag  [4];
  logic [TAG_W-1:0] slot_dtag [4];

  assign slot_vld     = {disp3_vld, disp2_vld, disp1_vld, disp0_vld};
  assign slot_dvld    = {disp3_dvld, disp2_dvld, disp1_dvld, disp0_dvld};
  assign slot_tag[0]  = disp0_tag;
  assign slot_tag[1]  = disp1_tag;
  assign slot_tag[2]  = disp2_tag;
  assign slot_tag[3]  = disp3_tag;
  assign slot_dtag[0] = disp0_dtag;
  assign slot_dtag[1] = disp1_dtag;
  assign slot_dtag[2] = disp2_dtag;
  assign slot_dtag[3] = disp3_dtag;

  // Wakeup first, then dispatch in ascending slot order so a later write overrides an earlier one.
  always_comb begin
    wait_d    = wait_q;
    dep_tag_d = dep_tag_q;
    for (int i = 0; i < NENT; i++) begin
      if ((st_iss0_vld && (dep_tag_q[i] == st_iss0_tag)) ||
          (st_iss1_vld && (dep_tag_q[i] == st_iss1_tag)))
        wait_d[i] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (slot_vld[k]) begin
        dep_tag_d[slot_tag[k]] = slot_dtag[k];
        wait_d[slot_tag[k]]    = slot_dvld[k] &
          ~((st_iss0_vld && (slot_dtag[k] == st_iss0_tag)) ||
            (st_iss1_vld && (slot_dtag[k] == st_iss1_tag)));
      end
    end
    inval0_d = {st_iss0_tag, st_iss0_vld};
    inval1_d = {st_iss1_tag, st_iss1_vld};
    if (flush_in) begin
      wait_d    = '0;
      dep_tag_d = dep_tag_q;
      inval0_d  = '0;
      inval1_d  = '0;
    end
    wait_cnt_d = '0;
    for (int i = 0; i < NENT; i++)
      wait_cnt_d = wait_cnt_d + {7'd0, wait_d[i]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_q     <= '0;
      dep_tag_q  <= '{default: '0};
      inval0_q   <= '0;
      inval1_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      wait_q     <= wait_d;
      dep_tag_q  <= dep_tag_d;
      inval0_q   <= inval0_d;
      inval1_q   <= inval1_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Queries see only registered state; this cycle's issue/dispatch shows up next cycle.
  assign q0_ready     = ~wait_q[q0_tag];
  assign q1_ready     = ~wait_q[q1_tag];
  assign inval0_out   = inval0_q;
  assign inval1_out   = inval1_q;
  assign wait_cnt_out = wait_cnt_q;

endmodule

// File: tb/tb_store_wait_table.sv
// Directed bench for store_wait_table: wait/wake, bypass, fan-out, dual issue, flush and reset.
module tb_store_wait_table;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       flush_in;
  logic       disp0_vld, disp0_dvld, disp1_vld, disp1_dvld;
  logic       disp2_vld, disp2_dvld, disp3_vld, disp3_dvld;
  logic [6:0] disp0_tag, disp0_dtag, disp1_tag, disp1_dtag;
  logic [6:0] disp2_tag, disp2_dtag, disp3_tag, disp3_dtag;
  logic       st_iss0_vld, st_iss1_vld;
  logic [6:0] st_iss0_tag, st_iss1_tag;
  logic [6:0] q0_tag, q1_tag;
  logic       q0_ready, q1_ready;
  logic [7:0] inval0_out, inval1_out, wait_cnt_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  store_wait_table dut (
    .clock(clock), .reset_n(reset_n), .flush_in(flush_in),
    .disp0_vld(disp0_vld), .disp0_tag(disp0_tag), .disp0_dvld(disp0_dvld), .disp0_dtag(disp0_dtag),
    .disp1_vld(disp1_vld), .disp1_tag(disp1_tag), .disp1_dvld(disp1_dvld), .disp1_dtag(disp1_dtag),
    .disp2_vld(disp2_vld), .disp2_tag(disp2_tag), .disp2_dvld(disp2_dvld), .disp2_dtag(disp2_dtag),
    .disp3_vld(disp3_vld), .disp3_tag(disp3_tag), .disp3_dvld(disp3_dvld), .disp3_dtag(disp3_dtag),
    .st_iss0_vld(st_iss0_vld), .st_iss0_tag(st_iss0_tag),
    .st_iss1_vld(st_iss1_vld), .st_iss1_tag(st_iss1_tag),
    .q0_tag(q0_tag), .q0_ready(q0_ready), .q1_tag(q1_tag), .q1_ready(q1_ready),
    .inval0_out(inval0_out), .inval1_out(inval1_out), .wait_cnt_out(wait_cnt_out)
  );

  task automatic clear_inputs();
    flush_in = 0;
    disp0_vld = 0; disp0_tag = 0; disp0_dvld = 0; disp0_dtag = 0;
    disp1_vld = 0; disp1_tag = 0; disp1_dvld = 0; disp1_dtag = 0;
    disp2_vld = 0; disp2_tag = 0; disp2_dvld = 0; disp2_dtag = 0;
    disp3_vld = 0; disp3_tag = 0; disp3_dvld = 0; disp3_dtag = 0;
    st_iss0_vld = 0; st_iss0_tag = 0; st_iss1_vld = 0; st_iss1_tag = 0;
  endtask

  // Clock the currently driven inputs in, then return the bus to idle just after the edge.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic query(input logic [6:0] t0, input logic [6:0] t1);
    q0_tag = t0;
    q1_tag = t1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    query(7'd5, 7'd0);
    #10;
    checkOutput("in_reset_ready", {7'd0, q0_ready}, 8'd1);
    checkOutput("in_reset_cnt", wait_cnt_out, 8'd0);
    reset_n = 1;
    #1;
    checkOutput("rst_ready", {7'd0, q0_ready}, 8'd1);
    checkOutput("rst_inval0", inval0_out, 8'h00);
    checkOutput("rst_inval1", inval1_out, 8'h00);
    checkOutput("rst_cnt", wait_cnt_out, 8'd0);

    // Basic wait then wake
    disp0_vld = 1; disp0_tag = 10; disp0_dvld = 1; disp0_dtag = 3;
    applyStimulus();
    query(7'd10, 7'd3);
    checkOutput("basic_wait_ready", {7'd0, q0_ready}, 8'd0);
    checkOutput("basic_other_ready", {7'd0, q1_ready}, 8'd1);
    checkOutput("basic_wait_cnt", wait_cnt_out, 8'd1);
    st_iss0_vld = 1; st_iss0_tag = 3;
    applyStimulus();
    query(7'd10, 7'd3);
    checkOutput("basic_wake_ready", {7'd0, q0_ready}, 8'd1);
    checkOutput("basic_wake_cnt", wait_cnt_out, 8'd0);
    checkOutput("basic_inval0", inval0_out, 8'h07);
    applyStimulus();
    checkOutput("basic_inval0_drop", inval0_out, 8'h00);

    // Same-cycle issue bypass
    disp1_vld = 1; disp1_tag = 20; disp1_dvld = 1; disp1_dtag = 4;
    st_iss1_vld = 1; st_iss1_tag = 4;
    applyStimulus();
    query(7'd0, 7'd20);
    checkOutput("bypass_ready", {7'd0, q1_ready}, 8'd1);
    checkOutput("bypass_cnt", wait_cnt_out, 8'd0);
    checkOutput("bypass_inval1", inval1_out, 8'h09);

    // Fan-out of one store to four consumers
    disp0_vld = 1; disp0_tag = 30; disp0_dvld = 1; disp0_dtag = 9;
    disp1_vld = 1; disp1_tag = 31; disp1_dvld = 1; disp1_dtag = 9;
    disp2_vld = 1; disp2_tag = 32; disp2_dvld = 1; disp2_dtag = 9;
    disp3_vld = 1; disp3_tag = 33; disp3_dvld = 1; disp3_dtag = 9;
    applyStimulus();
    query(7'd30, 7'd33);
    checkOutput("fan_cnt", wait_cnt_out, 8'd4);
    checkOutput("fan_wait30", {7'd0, q0_ready}, 8'd0);
    checkOutput("fan_wait33", {7'd0, q1_ready}, 8'd0);
    st_iss0_vld = 1; st_iss0_tag = 9;
    applyStimulus();
    query(7'd31, 7'd32);
    checkOutput("fan_wake_cnt", wait_cnt_out, 8'd0);
    checkOutput("fan_wake31", {7'd0, q0_ready}, 8'd1);
    checkOutput("fan_wake32", {7'd0, q1_ready}, 8'd1);

    // Dual issue, plus a non-matching dvld=0 op
    disp0_vld = 1; disp0_tag = 40; disp0_dvld = 1; disp0_dtag = 1;
    disp1_vld = 1; disp1_tag = 41; disp1_dvld = 1; disp1_dtag = 2;
    disp2_vld = 1; disp2_tag = 42; disp2_dvld = 0; disp2_dtag = 2;
    applyStimulus();
    query(7'd40, 7'd42);
    checkOutput("dual_cnt", wait_cnt_out, 8'd2);
    checkOutput("dual_wait40", {7'd0, q0_ready}, 8'd0);
    checkOutput("dual_nodep42", {7'd0, q1_ready}, 8'd1);
    st_iss0_vld = 1; st_iss0_tag = 1; st_iss1_vld = 1; st_iss1_tag = 2;
    applyStimulus();
    query(7'd40, 7'd41);
    checkOutput("dual_ready40", {7'd0, q0_ready}, 8'd1);
    checkOutput("dual_ready41", {7'd0, q1_ready}, 8'd1);
    checkOutput("dual_inval0", inval0_out, 8'h03);
    checkOutput("dual_inval1", inval1_out, 8'h05);
    checkOutput("dual_cnt0", wait_cnt_out, 8'd0);

    // Self-dependence and issue on port 1 only
    disp0_vld = 1; disp0_tag = 70; disp0_dvld = 1; disp0_dtag = 70;
    applyStimulus();
    query(7'd70, 7'd0);
    checkOutput("self_wait", {7'd0, q0_ready}, 8'd0);
    st_iss1_vld = 1; st_iss1_tag = 70;
    applyStimulus();
    query(7'd70, 7'd0);
    checkOutput("self_wake", {7'd0, q0_ready}, 8'd1);
    checkOutput("self_inval1", inval1_out, 8'h8D);

    // Illegal same-tag dispatch: highest slot wins
    disp0_vld = 1; disp0_tag = 80; disp0_dvld = 1; disp0_dtag = 11;
    disp2_vld = 1; disp2_tag = 80; disp2_dvld = 0; disp2_dtag = 0;
    applyStimulus();
    query(7'd80, 7'd0);
    checkOutput("prio_ready", {7'd0, q0_ready}, 8'd1);
    checkOutput("prio_cnt", wait_cnt_out, 8'd0);

    // Dispatch write beats a same-cycle wakeup clear of the same entry
    disp0_vld = 1; disp0_tag = 85; disp0_dvld = 1; disp0_dtag = 16;
    applyStimulus();
    disp0_vld = 1; disp0_tag = 85; disp0_dvld = 1; disp0_dtag = 17;
    st_iss0_vld = 1; st_iss0_tag = 16;
    applyStimulus();
    query(7'd85, 7'd0);
    checkOutput("dispwin_wait", {7'd0, q0_ready}, 8'd0);
    checkOutput("dispwin_cnt", wait_cnt_out, 8'd1);
    st_iss0_vld = 1; st_iss0_tag = 17;
    applyStimulus();
    query(7'd85, 7'd0);
    checkOutput("dispwin_wake", {7'd0, q0_ready}, 8'd1);

    // Flush drops everything including same-cycle dispatch and issue
    disp0_vld = 1; disp0_tag = 90; disp0_dvld = 1; disp0_dtag = 12;
    disp1_vld = 1; disp1_tag = 91; disp1_dvld = 1; disp1_dtag = 12;
    disp2_vld = 1; disp2_tag = 92; disp2_dvld = 1; disp2_dtag = 12;
    applyStimulus();
    query(7'd90, 7'd0);
    checkOutput("preflush_cnt", wait_cnt_out, 8'd3);
    flush_in = 1;
    disp0_vld = 1; disp0_tag = 50; disp0_dvld = 1; disp0_dtag = 13;
    st_iss0_vld = 1; st_iss0_tag = 12;
    applyStimulus();
    query(7'd50, 7'd90);
    checkOutput("flush_cnt", wait_cnt_out, 8'd0);
    checkOutput("flush_ready50", {7'd0, q0_ready}, 8'd1);
    checkOutput("flush_ready90", {7'd0, q1_ready}, 8'd1);
    checkOutput("flush_inval0", inval0_out, 8'h00);

    // Asynchronous reset mid-operation
    disp0_vld = 1; disp0_tag = 100; disp0_dvld = 1; disp0_dtag = 14;
    st_iss0_vld = 1; st_iss0_tag = 15;
    applyStimulus();
    query(7'd100, 7'd0);
    checkOutput("prerst_cnt", wait_cnt_out, 8'd1);
    checkOutput("prerst_inval0", inval0_out, 8'h1F);
    reset_n = 0;
    #1;
    checkOutput("async_rst_cnt", wait_cnt_out, 8'd0);
    checkOutput("async_rst_ready", {7'd0, q0_ready}, 8'd1);
    checkOutput("async_rst_inval0", inval0_out, 8'h00);
    reset_n = 1;
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
